// File: rtl/mem_access_unit.sv
// Load/store unit: takes one RISC-V load or store, runs it as a single bus cycle
// with lane steering and timeout, and returns a sign/zero-extended response.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic [1:0]        dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the valid side holds its payload stable until that edge and never withdraws it.

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   ((XLEN == 64) && (f3 == 3'b011));
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101) ||
               ((XLEN == 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return off[0] == 1'b0;
            2'd2:    return off[1:0] == 2'b00;
            default: return off == '0;
        endcase
    endfunction

    // Lane steering is decoded from the latched request, so it stays stable for the whole bus cycle.
    logic [OFF_W-1:0] off;
    logic [OFF_W+2:0] bit_off;
    logic [NB-1:0]    sz_be;
    logic [XLEN-1:0]  lane_mask;
    logic [XLEN-1:0]  rd_sh;
    logic             sign_bit;
    logic [XLEN-1:0]  ld_data;

    assign off     = addr_q[OFF_W-1:0];
    assign bit_off = {off, 3'b000};
    assign rd_sh   = mem_rdata_i >> bit_off;

    always_comb begin
        sz_be    = '1;
        sign_bit = 1'b0;
        case (f3_q[1:0])
            2'd0: begin sz_be = NB'(1);  sign_bit = rd_sh[7];  end
            2'd1: begin sz_be = NB'(3);  sign_bit = rd_sh[15]; end
            2'd2: begin sz_be = NB'(15); sign_bit = rd_sh[31]; end
            default: ;
        endcase
        lane_mask = '0;
        for (int i = 0; i < NB; i++) lane_mask[i*8 +: 8] = {8{sz_be[i]}};
        ld_data = (rd_sh & lane_mask) | ((sign_bit && !f3_q[2]) ? ~lane_mask : '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid_i && ready_q) begin
                we_d    = req_we_i;
                f3_d    = req_funct3_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                if (is_legal(req_we_i, req_funct3_i) &&
                    is_aligned(req_funct3_i[1:0], req_addr_i[OFF_W-1:0])) begin
                    state_d = S_BUS;
                end else begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_BUS: if (mem_gnt_i) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: if (mem_rvalid_i) begin
                state_d = S_RESP;
                err_d   = 1'b0;
                rdata_d = we_q ? '0 : ld_data;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                state_d = S_RESP;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: if (rsp_ready_i) state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic in_bus, in_resp;
    assign in_bus  = (state_q == S_BUS);
    assign in_resp = (state_q == S_RESP);

    assign req_ready_o = ready_q;
    assign rsp_valid_o = in_resp;
    assign rsp_rdata_o = in_resp ? rdata_q : '0;
    assign rsp_err_o   = in_resp & err_q;
    assign mem_req_o   = in_bus;
    assign mem_we_o    = in_bus & we_q;
    assign mem_be_o    = in_bus ? (sz_be << off) : '0;
    assign mem_addr_o  = in_bus ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata_o = (in_bus && we_q) ? ((wdata_q & lane_mask) << bit_off) : '0;
    assign dbg_state_o = state_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles spent waiting for mem_rvalid_i; legal range 2..255.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid_i  in  1 / req_ready_o  out  1  request handshake.
REQ-007 req_we_i  in  1  1=store, 0=load.
REQ-008 req_funct3_i  in  3  RISC-V load/store funct3.
REQ-009 req_addr_i  in  ADDR_W  byte address / req_wdata_i  in  XLEN  store data, LSB-aligned.
REQ-010 rsp_valid_o  out  1 / rsp_ready_i  in  1  response handshake.
REQ-011 rsp_rdata_o  out  XLEN  extended load data (0 for stores) / rsp_err_o  out  1  misaligned, illegal or timeout.
REQ-012 mem_req_o  out  1 / mem_gnt_i  in  1  bus request handshake.
REQ-013 mem_we_o  out  1 / mem_be_o  out  XLEN/8 / mem_addr_o  out  ADDR_W (low log2(XLEN/8) bits 0) / mem_wdata_o  out  XLEN (lane-shifted).
REQ-014 mem_rvalid_i  in  1 / mem_rdata_i  in  XLEN  completion for loads and stores; rdata full aligned word.

Function
REQ-015 SHALL implement FSM IDLE, BUS, WAIT, RESP.
REQ-016 IDLE: req_ready_o=1; on req_valid_i, latch we, funct3, addr, wdata.
REQ-017 IDLE accepted, legal, aligned -> BUS; illegal or misaligned -> RESP, rsp_err_o=1, rsp_rdata_o=0, no bus cycle.
REQ-018 Legal funct3: loads 000,001,010,100,101; stores 000,001,010; XLEN=64 also loads 011,110, store 011; all else illegal.
REQ-019 Size: 00x/10x byte and half per funct3[1:0]; 010/110 word; 011 double. Misaligned when addr mod size != 0.
REQ-020 BUS: mem_req_o=1, holds addr/we/be/wdata stable until mem_gnt_i=1; then -> WAIT, mem_req_o=0 next cycle.
REQ-021 mem_be_o = size-wide contiguous mask shifted left by addr offset within XLEN/8; loads drive the same mask.
REQ-022 mem_wdata_o = req_wdata size-LSBs replicated/shifted to offset lane; bytes outside mask don't-care but driven 0.
REQ-023 WAIT: 8-bit counter from 0, +1 per cycle; mem_rvalid_i=1 -> RESP, err=0; counter reaching TIMEOUT-1 without rvalid -> RESP, err=1, rdata=0.
REQ-024 Load data: select lane at offset, sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to XLEN.
REQ-025 RESP: rsp_valid_o=1, rsp outputs registered and stable until rsp_ready_i=1; then -> IDLE.
REQ-026 req_ready_o=0 in BUS, WAIT, RESP; one outstanding transaction max.
REQ-027 mem_rvalid_i outside WAIT SHALL be ignored, including in the cycle of mem_gnt_i.
REQ-028 Late rvalid after timeout SHALL be ignored.
REQ-029 Minimum latency, legal access: accept edge N, mem_req_o high N..N+1, gnt at N+1, rvalid at N+2, rsp_valid_o at N+3.
REQ-030 Error path latency: rsp_valid_o asserted cycle after acceptance.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and all outputs 0 except req_ready_o, 0 during reset, 1 from first edge after release; counter and latches cleared.
REQ-032 Reset mid-transaction SHALL abandon it with no response; mem_req_o drops asynchronously.

Verification
REQ-033 XLEN=32, LB addr 0x103, mem_rdata 0x80FF_1234 -> mem_be_o=4'b1000, addr 0x100, rsp_rdata_o=0xFFFF_FF80, err=0.
REQ-034 SH addr 0x202, wdata 0x0000_ABCD -> mem_be_o=4'b1100, mem_wdata_o=0xABCD_0000, mem_we_o=1, rsp_rdata_o=0.
REQ-035 LW addr 0x101 -> no mem_req_o, rsp_valid_o next cycle, rsp_err_o=1; funct3=011 at XLEN=32 -> same.
REQ-036 TIMEOUT=4, LHU, mem_rvalid_i held 0 -> rsp_err_o=1 after 4 WAIT cycles; rvalid pulse afterward ignored.
REQ-037 XLEN=64, LWU addr 0x1004, rdata 0x8765_4321_0000_0000 -> be=8'hF0, rsp_rdata_o=0x0000_0000_8765_4321.
REQ-038 gnt delayed 3 cycles, rsp_ready_i delayed 2 cycles, rst_n pulsed during WAIT -> bus fields stable, response stable, reset returns IDLE without rsp_valid_o.
